// File: rtl/dmux_stream_nway.sv
// Registered 1-to-N stream demultiplexer with one-entry holding register, per-channel backpressure
// and out-of-range select dropping. Define DMUX_STREAM_ZERO_IDLE_EN to zero unselected out_data lanes.
module dmux_stream_nway #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          sel,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      drop,
    output logic [7:0]                drop_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [SEL_W:0] CH_LIMIT = CHANNELS[SEL_W:0];

    state_t               r_state;
    logic [WIDTH-1:0]     r_data;
    logic [SEL_W-1:0]     r_sel;
    logic                 r_drop;
    logic [7:0]           r_drop_count;

    logic                 w_full;
    logic                 w_sel_legal;
    logic                 w_accept;
    logic                 w_drain;
    logic [CHANNELS-1:0]  w_out_valid;

    assign w_full      = (r_state == FULL);
    assign w_sel_legal = ({1'b0, sel} < CH_LIMIT);

    // Decode the held select into one-hot valids; masking out_ready with them avoids
    // indexing out_ready by a select that could exceed the channel count.
    always_comb begin
        w_out_valid = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_out_valid[i] = w_full && (r_sel == i[SEL_W-1:0]);
        end
    end

    assign w_drain  = |(w_out_valid & out_ready);
    assign in_ready = !w_full || w_drain;
    assign w_accept = in_valid && in_ready;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values;
    // the holding register is reset too, so out_data is defined straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= EMPTY;
            r_data       <= '0;
            r_sel        <= '0;
            r_drop       <= 1'b0;
            r_drop_count <= 8'd0;
        end else begin
            r_drop <= w_accept && !w_sel_legal;
            if (w_accept && !w_sel_legal && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
            // A legal accept always refills; an illegal one only lets a drain empty the slot.
            if (w_accept && w_sel_legal) begin
                r_state <= FULL;
                r_data  <= in_data;
                r_sel   <= sel;
            end else if (w_drain) begin
                r_state <= EMPTY;
            end
        end
    end

    assign out_valid  = w_out_valid;
    assign drop       = r_drop;
    assign drop_count = r_drop_count;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
`ifdef DMUX_STREAM_ZERO_IDLE_EN
        assign out_data[g*WIDTH +: WIDTH] = w_out_valid[g] ? r_data : '0;
`else
        assign out_data[g*WIDTH +: WIDTH] = r_data;
`endif
    end

endmodule

// File: tb/tb_dmux_stream_nway.sv
// Directed bench for dmux_stream_nway: a 4-channel instance for the main handshake and a
// 3-channel instance for out-of-range select dropping and counter saturation.
module tb_dmux_stream_nway;

`ifdef DMUX_STREAM_ZERO_IDLE_EN
    localparam bit ZERO_IDLE = 1'b1;
`else
    localparam bit ZERO_IDLE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready;
    logic [7:0]  in_data;
    logic [1:0]  sel;
    logic [3:0]  out_valid, out_ready;
    logic [31:0] out_data;
    logic        drop;
    logic [7:0]  drop_count;

    logic        in_valid3, in_ready3;
    logic [7:0]  in_data3;
    logic [1:0]  sel3;
    logic [2:0]  out_valid3, out_ready3;
    logic [23:0] out_data3;
    logic        drop3;
    logic [7:0]  drop_count3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmux_stream_nway #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drop(drop), .drop_count(drop_count)
    );

    dmux_stream_nway #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .sel(sel3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .drop(drop3), .drop_count(drop_count3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_data = 8'h00; sel = 2'd0; out_ready = 4'h0;
        in_valid3 = 1'b0; in_data3 = 8'h00; sel3 = 2'd0; out_ready3 = 3'h0;
        #12;
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid got=%b exp=%b", out_valid, 4'b0000); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (drop !== 1'b0 || drop_count !== 8'd0) begin
            errors++; $display("FAIL reset_drop got=%b/%0d exp=0/0", drop, drop_count);
        end
        checks++;
        if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic [7:0] idle;
        idle = ZERO_IDLE ? 8'h00 : 8'hA5;
        out_ready = 4'hF;
        in_valid = 1'b1; in_data = 8'hA5; sel = 2'd2;
        step();
        in_valid = 1'b0; in_data = 8'h00;
        checks++;
        if (out_valid !== 4'b0100) begin errors++; $display("FAIL single_valid got=%b exp=0100", out_valid); end
        checks++;
        if (out_data[23:16] !== 8'hA5) begin errors++; $display("FAIL single_lane2 got=%h exp=a5", out_data[23:16]); end
        checks++;
        if (out_data[7:0] !== idle || out_data[15:8] !== idle || out_data[31:24] !== idle) begin
            errors++; $display("FAIL single_idle_lanes got=%h exp_idle=%h", out_data, idle);
        end
        step();
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL single_drain got=%b exp=0000", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_v;
        logic [7:0] exp_d;
        out_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 8'(k + 1); sel = 2'(k);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready beat=%0d got=%b exp=1", k, in_ready); end
            step();
            exp_v = 4'b0001 << k;
            exp_d = 8'(k + 1);
            checks++;
            if (out_valid !== exp_v || out_data[k*8 +: 8] !== exp_d) begin
                errors++; $display("FAIL b2b_out beat=%0d got=%b/%h exp=%b/%h", k, out_valid, out_data[k*8 +: 8], exp_v, exp_d);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL b2b_drain got=%b exp=0000", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 4'b1101;
        in_valid = 1'b1; in_data = 8'h3C; sel = 2'd1;
        step();
        in_data = 8'h7E; sel = 2'd3;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 4'b0010 || out_data[15:8] !== 8'h3C) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d got rdy=%b v=%b d=%h exp rdy=0 v=0010 d=3c", c, in_ready, out_valid, out_data[15:8]);
            end
            step();
        end
        out_ready = 4'hF;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'b1000 || out_data[31:24] !== 8'h7E) begin
            errors++; $display("FAIL bp_pending got=%b/%h exp=1000/7e", out_valid, out_data[31:24]);
        end
        step();
    endtask

    task automatic test_wrong_ready();
        out_ready = 4'b0100;
        in_valid = 1'b1; in_data = 8'h55; sel = 2'd0;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 4'b0001 || out_data[7:0] !== 8'h55 || in_ready !== 1'b0) begin
            errors++; $display("FAIL wrong_ready got=%b/%h/rdy=%b exp=0001/55/rdy=0", out_valid, out_data[7:0], in_ready);
        end
    endtask

    task automatic test_drop();
        out_ready3 = 3'b111;
        in_valid3 = 1'b1; in_data3 = 8'h99; sel3 = 2'd3;
        #1;
        checks++;
        if (in_ready3 !== 1'b1) begin errors++; $display("FAIL drop_in_ready got=%b exp=1", in_ready3); end
        step();
        in_valid3 = 1'b0;
        checks++;
        if (out_valid3 !== 3'b000 || drop3 !== 1'b1 || drop_count3 !== 8'd1) begin
            errors++; $display("FAIL drop_pulse got v=%b drop=%b cnt=%0d exp v=000 drop=1 cnt=1", out_valid3, drop3, drop_count3);
        end
        step();
        checks++;
        if (drop3 !== 1'b0 || drop_count3 !== 8'd1) begin
            errors++; $display("FAIL drop_one_cycle got drop=%b cnt=%0d exp drop=0 cnt=1", drop3, drop_count3);
        end
        // Illegal beat arriving while a held beat drains: slot empties, beat is dropped.
        in_valid3 = 1'b1; in_data3 = 8'h11; sel3 = 2'd1;
        step();
        in_data3 = 8'h22; sel3 = 2'd3;
        step();
        in_valid3 = 1'b0;
        checks++;
        if (out_valid3 !== 3'b000 || drop3 !== 1'b1 || drop_count3 !== 8'd2) begin
            errors++; $display("FAIL drop_with_drain got v=%b drop=%b cnt=%0d exp v=000 drop=1 cnt=2", out_valid3, drop3, drop_count3);
        end
        in_valid3 = 1'b1; sel3 = 2'd3;
        repeat (300) @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        step();
        checks++;
        if (drop_count3 !== 8'd255) begin errors++; $display("FAIL drop_saturate got=%0d exp=255", drop_count3); end
        // Hold a beat on channel 0 so the async reset has something to lose.
        out_ready3 = 3'b000;
        in_valid3 = 1'b1; in_data3 = 8'h44; sel3 = 2'd0;
        step();
        in_valid3 = 1'b0;
    endtask

    task automatic test_async_reset();
        checks++;
        if (out_valid !== 4'b0001 || out_valid3 !== 3'b001) begin
            errors++; $display("FAIL areset_pre got=%b/%b exp=0001/001", out_valid, out_valid3);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 4'b0000 || in_ready !== 1'b1 || drop_count !== 8'd0) begin
            errors++; $display("FAIL areset_dut got v=%b rdy=%b cnt=%0d exp v=0000 rdy=1 cnt=0", out_valid, in_ready, drop_count);
        end
        checks++;
        if (out_valid3 !== 3'b000 || in_ready3 !== 1'b1 || drop_count3 !== 8'd0 || drop3 !== 1'b0) begin
            errors++; $display("FAIL areset_dut3 got v=%b rdy=%b cnt=%0d drop=%b exp v=000 rdy=1 cnt=0 drop=0", out_valid3, in_ready3, drop_count3, drop3);
        end
        #1;
        rst = 1'b0;
        step();
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL areset_after got=%b exp=0000", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wrong_ready();
        test_drop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
